uart_word_assembler: RTL and testbench

//  Upstream of the matrix pre-processor. Packs UART receiver bytes into 32-bit words (LSB byte first).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/byte_packer.sv | 52 +++++
 rtl/uart_word_assembler.sv | 146 ++++++++++++++
 tb/tb_uart_word_assembler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Brief  : Shared types and helpers for the UART word assembler.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {HDR, PAYLOAD} asm_state_t;

    typedef struct packed {
        logic [15:0] cols;
        logic [15:0] rows;
    } mat_dim_t;

    // Number of payload words announced by a header; 16x16 product fits in a word.
    function automatic logic [WORD_W-1:0] dim_words(input mat_dim_t dim);
        return WORD_W'(dim.cols) * WORD_W'(dim.rows);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : byte_packer                                                       |
// | Brief  : Packs UART bytes LSB-first into words; word_done marks the cycle  |
// |          the final byte arrives so the word can be captured on that edge.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module byte_packer
    import uart_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic              partial
);

    localparam int c_IDX_W = $clog2(BYTES_PER_WORD);
    localparam int c_BUF_W = WORD_W - 8;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(BYTES_PER_WORD - 1);

    logic [c_IDX_W-1:0] r_idx;
    logic [c_BUF_W-1:0] r_buf;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx <= '0;
            r_buf <= '0;
        end else if (flush) begin
            r_idx <= '0;
        end else if (rx_valid) begin
            if (r_idx == c_LAST) begin
                r_idx <= '0;
            end else begin
                r_buf[{r_idx, 3'b000} +: 8] <= rx_byte;
                r_idx                       <= r_idx + 1'b1;
            end
        end
    end

    // The last byte bypasses the buffer so the full word is visible in its arrival cycle.
    assign word      = {rx_byte, r_buf};
    assign word_done = rx_valid && (r_idx == c_LAST);
    assign partial   = (r_idx != '0);

endmodule
`default_nettype wire

// File: rtl/uart_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_word_assembler                                               |
// | Brief  : Frames UART bytes into header/payload words with a 1-entry hold   |
// |          register. Define WORD_ASM_TIMEOUT_EN for the inter-byte timeout.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYC    = 50000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [WORD_W-1:0] s_data,
    output logic              data_valid,
    input  logic              s_ready,
    output logic              is_header,
    output logic              frame_done,
    output logic              overflow,
    output logic              timeout_err
);

    logic [WORD_W-1:0] w_word;
    logic              w_word_done;
    logic              w_partial;
    logic              w_flush;

    byte_packer #(
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .flush     (w_flush),
        .word      (w_word),
        .word_done (w_word_done),
        .partial   (w_partial)
    );

    asm_state_t        r_state;
    logic [WORD_W-1:0] r_rem;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;
    logic              r_hdr;
    logic              r_last;
    logic              r_frame_done;
    logic              r_overflow;

    logic              w_xfer;
    logic              w_load;
    logic [WORD_W-1:0] w_hdr_words;
    logic              w_word_last;

    assign w_xfer      = r_valid && s_ready;
    assign w_load      = w_word_done && (!r_valid || s_ready);
    assign w_hdr_words = dim_words(mat_dim_t'(w_word));
    // A word closes its frame if it is an empty header or the final payload word.
    assign w_word_last = (r_state == HDR) ? (w_hdr_words == '0) : (r_rem == WORD_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= HDR;
            r_rem        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_hdr        <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && r_last;

            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
                r_hdr   <= (r_state == HDR);
                r_last  <= w_word_last;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (w_word_done && !w_load) begin
                r_overflow <= 1'b1;
            end

            // Framing follows the byte stream, so dropped words still count.
            if (w_word_done) begin
                if (r_state == HDR) begin
                    r_rem   <= w_hdr_words;
                    r_state <= (w_hdr_words == '0) ? HDR : PAYLOAD;
                end else begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == WORD_W'(1)) begin
                        r_state <= HDR;
                    end
                end
            end
        end
    end

    assign s_data     = r_data;
    assign data_valid = r_valid;
    assign is_header  = r_hdr;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

`ifdef WORD_ASM_TIMEOUT_EN
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] r_idle;
    logic        r_timeout;

    assign w_flush = w_partial && !rx_valid && (r_idle == c_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else if (rx_valid || !w_partial) begin
            r_idle <= '0;
        end else if (w_flush) begin
            r_idle    <= '0;
            r_timeout <= 1'b1;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign timeout_err = r_timeout;
`else
    logic        w_unused_partial;
    logic [31:0] w_unused_timeout;

    assign w_unused_partial = w_partial;
    assign w_unused_timeout = 32'(TIMEOUT_CYC);
    assign w_flush          = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_word_assembler                                            |
// | Brief  : Directed + random bench for uart_word_assembler against a frame   |
// |          model; honours WORD_ASM_TIMEOUT_EN.                               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_word_assembler;

    localparam int c_TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        s_ready = 1'b0;
    logic [31:0] s_data;
    logic        data_valid;
    logic        is_header;
    logic        frame_done;
    logic        overflow;
    logic        timeout_err;

    int n_err = 0;
    int n_chk = 0;

    uart_word_assembler #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYC    (c_TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .s_data      (s_data),
        .data_valid  (data_valid),
        .s_ready     (s_ready),
        .is_header   (is_header),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Frame model: byte accumulator, words-left counter and the one-slot output.
    bit          m_init = 0;
    int          m_cnt = 0;
    int          m_idle = 0;
    logic [31:0] m_acc = '0;
    bit          m_in_hdr = 1;
    longint      m_left = 0;
    bit          m_hv = 0;
    logic [31:0] m_hd = '0;
    bit          m_hh = 0;
    bit          m_hlast = 0;
    bit          m_fd = 0;
    bit          m_ov = 0;
    bit          m_to = 0;

    always @(posedge clk) begin
        bit          xfer;
        bit          word;
        bit          last;
        bit          hdr;
        logic [31:0] wd;
        m_init = 1;
        if (!rstn) begin
            m_cnt = 0; m_idle = 0; m_acc = '0; m_in_hdr = 1; m_left = 0;
            m_hv = 0; m_hd = '0; m_hh = 0; m_hlast = 0; m_fd = 0; m_ov = 0; m_to = 0;
        end else begin
            xfer = m_hv && s_ready;
            m_fd = xfer && m_hlast;
            word = 0;
            wd   = '0;
            if (rx_valid) begin
                m_acc[8*m_cnt +: 8] = rx_byte;
                m_cnt  = m_cnt + 1;
                m_idle = 0;
                if (m_cnt == 4) begin
                    word  = 1;
                    wd    = m_acc;
                    m_cnt = 0;
                end
            end
`ifdef WORD_ASM_TIMEOUT_EN
            if (!rx_valid && m_cnt != 0) begin
                m_idle = m_idle + 1;
                if (m_idle == c_TO) begin
                    m_cnt = 0; m_idle = 0; m_to = 1;
                end
            end
`endif
            if (word) begin
                hdr = m_in_hdr;
                if (m_in_hdr) begin
                    m_left = longint'(wd[31:16]) * longint'(wd[15:0]);
                end else begin
                    m_left = m_left - 1;
                end
                last     = (m_left == 0);
                m_in_hdr = last;
                if (!m_hv || s_ready) begin
                    m_hv = 1; m_hd = wd; m_hh = hdr; m_hlast = last;
                end else begin
                    m_ov = 1;
                end
            end else if (xfer) begin
                m_hv = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("model.data_valid", data_valid, m_hv);
            if (m_hv) begin
                chk("model.s_data", s_data, m_hd);
                chk("model.is_header", is_header, m_hh);
            end
            chk("model.frame_done", frame_done, m_fd);
            chk("model.overflow", overflow, m_ov);
            chk("model.timeout_err", timeout_err, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    function automatic logic [7:0] pick_byte();
        if (m_in_hdr) begin
            if (m_cnt == 0 || m_cnt == 2) return 8'($urandom_range(0, 3));
            return 8'h00;
        end
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int gap;
        rstn = 1'b0;
        repeat (3) tick();
        chk("reset.data_valid", data_valid, 0);
        chk("reset.s_data", s_data, 32'h0);
        chk("reset.flags", {is_header, frame_done, overflow, timeout_err}, 4'b0000);
        rstn = 1'b1;
        tick();

        // 2x2 frame: header held, then four payload words streamed.
        s_ready = 1'b0;
        send_word(32'h0002_0002);
        chk("hdr.data_valid", data_valid, 1);
        chk("hdr.s_data", s_data, 32'h0002_0002);
        chk("hdr.is_header", is_header, 1);
        s_ready = 1'b1;
        tick();
        chk("hdr.released", data_valid, 0);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        chk("pay.latency_before", data_valid, 0);
        send_byte(8'h12);
        chk("pay.latency_after", data_valid, 1);
        chk("pay.s_data", s_data, 32'h1234_5678);
        chk("pay.is_header", is_header, 0);
        send_word(32'hA5A5_0001);
        send_word(32'hA5A5_0002);
        send_word(32'hA5A5_0003);
        chk("frame.no_early_done", frame_done, 0);
        tick();
        chk("frame.done_pulse", frame_done, 1);
        tick();
        chk("frame.done_clears", frame_done, 0);

        // Completion coincides with a transfer: new word replaces old without overflow.
        send_word(32'h0001_0002);
        tick();
        s_ready = 1'b0;
        send_word(32'hDDCC_BBAA);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("same.held", s_data, 32'hDDCC_BBAA);
        s_ready = 1'b1;
        send_byte(8'h44);
        chk("same.data_valid", data_valid, 1);
        chk("same.s_data", s_data, 32'h4433_2211);
        chk("same.no_overflow", overflow, 0);
        tick();
        chk("same.frame_done", frame_done, 1);

        // Overflow: two payload words arrive while the header is still held.
        s_ready = 1'b0;
        send_word(32'h0001_0002);
        send_word(32'h0403_0201);
        chk("ovf.flag", overflow, 1);
        chk("ovf.held_intact", s_data, 32'h0001_0002);
        chk("ovf.held_is_header", is_header, 1);
        send_word(32'h0807_0605);
        s_ready = 1'b1;
        tick();
        send_word(32'h0000_0000);
        chk("zero.is_header", is_header, 1);
        chk("zero.s_data", s_data, 32'h0);
        tick();
        chk("zero.frame_done", frame_done, 1);
        send_word(32'h0001_0001);
        chk("zero.next_is_header", is_header, 1);
        send_word(32'h0C0B_0A09);
        chk("one.payload", is_header, 0);
        tick();
        chk("ovf.sticky", overflow, 1);

        // Reset mid-frame: next word must be treated as a header.
        send_word(32'h0001_0001);
        send_byte(8'hEE); send_byte(8'hEE);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst.overflow_cleared", overflow, 0);
        send_word(32'h0000_0005);
        chk("rst.is_header", is_header, 1);
        chk("rst.s_data", s_data, 32'h0000_0005);
        tick();

`ifdef WORD_ASM_TIMEOUT_EN
        s_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22);
        repeat (c_TO + 4) tick();
        chk("to.flag", timeout_err, 1);
        send_word(32'h0000_0000);
        chk("to.realigned", s_data, 32'h0);
        chk("to.is_header", is_header, 1);
        s_ready = 1'b1;
        tick();
`endif

        // Random traffic checked cycle-by-cycle against the model.
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            s_ready = ($urandom_range(0, 3) != 0);
            rstn    = (i != 2000);
            if (gap > 0) begin
                rx_valid = 1'b0;
                gap--;
            end else begin
                rx_valid = 1'b1;
                rx_byte  = pick_byte();
                gap      = $urandom_range(0, 2);
`ifdef WORD_ASM_TIMEOUT_EN
                if ($urandom_range(0, 40) == 0) gap = c_TO + 3;
`endif
            end
            tick();
        end
        rx_valid = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
